// File: rtl/sprite_pkg.sv
// Shared dimensions, state encoding and address helpers for the sprite row fetcher.
package sprite_pkg;

  localparam int MARIO_W   = 26;
  localparam int MARIO_H   = 32;
  localparam int BLOCK_W   = 32;
  localparam int BLOCK_H   = 32;
  localparam int MARIO_PIX = 3;
  localparam int BLOCK_PIX = 2;

  localparam int ROW_W  = 6;
  localparam int ADDR_W = 10;
  localparam int COL_W  = 5;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH_M = 3'd1,
    FETCH_B = 3'd2,
    DRAIN   = 3'd3,
    COMMIT  = 3'd4
  } fetch_state_t;

  function automatic logic row_live(input logic [ROW_W-1:0] row, input int h);
    return int'(row) < h;
  endfunction

  // Rows past the sprite height park the address bus at 0 rather than wrapping.
  function automatic logic [ADDR_W-1:0] rom_addr(input logic [ROW_W-1:0] row,
                                                 input logic [COL_W-1:0] col,
                                                 input int w, input int h);
    int idx;
    if (int'(row) >= h) return '0;
    idx = int'(row) * w + int'(col);
    return idx[ADDR_W-1:0];
  endfunction

endpackage

// File: rtl/sprite_row_fetcher_line_dbuf.sv
// One sprite line, double-buffered: a shadow row filled pixel by pixel and a
// visible row that only changes when commit is asserted.
module line_dbuf #(
  parameter int W   = 26,
  parameter int PIX = 3,
  localparam int IW = (W > 1) ? $clog2(W) : 1
) (
  input  logic           clk,
  input  logic           Reset,
  input  logic           wr_en,
  input  logic [IW-1:0]  wr_idx,
  input  logic [PIX-1:0] wr_data,
  input  logic           commit,
  output logic [W*PIX-1:0] line
);

  logic [W*PIX-1:0] shadow_q;
  logic [W*PIX-1:0] line_q;

  always_ff @(posedge clk) begin
    if (Reset) begin
      shadow_q <= '0;
      line_q   <= '0;
    end else begin
      if (wr_en) begin
        for (int c = 0; c < W; c++) begin
          if (wr_idx == IW'(c)) shadow_q[c*PIX +: PIX] <= wr_data;
        end
      end
      // Every slot is rewritten on each fetch, so the shadow never needs clearing.
      if (commit) line_q <= shadow_q;
    end
  end

  assign line = line_q;

endmodule

// File: rtl/sprite_row_fetcher.sv
// Fetches one mario row and one block row from their registered-read ROMs and
// publishes both as stable, double-buffered lines for the renderer.
module sprite_row_fetcher
  import sprite_pkg::*;
(
  input  logic                       clk,
  input  logic                       Reset,
  input  logic                       start,
  input  logic [ROW_W-1:0]           mario_row,
  input  logic [ROW_W-1:0]           block_row,
  input  logic                       mario_en,
  input  logic                       block_en,
  output logic [ADDR_W-1:0]          mario_addr,
  input  logic [MARIO_PIX-1:0]       mario_q,
  output logic [ADDR_W-1:0]          block_addr,
  input  logic [BLOCK_PIX-1:0]       block_q,
  output logic                       busy,
  output logic                       done,
  output logic [MARIO_PIX*MARIO_W-1:0] mario_line,
  output logic [BLOCK_PIX*BLOCK_W-1:0] block_line,
  output fetch_state_t               state_dbg
);

  // Handshake: start is a one-cycle request taken only while busy is low (IDLE);
  // requests while busy are dropped, never queued. done pulses for exactly one
  // cycle in the first cycle the new lines are visible, with busy already low.

  localparam logic [COL_W-1:0] M_LAST = COL_W'(MARIO_W - 1);
  localparam logic [COL_W-1:0] B_LAST = COL_W'(BLOCK_W - 1);

  fetch_state_t     state_q;
  logic [COL_W-1:0] col_q;
  logic [ROW_W-1:0] m_row_q;
  logic [ROW_W-1:0] b_row_q;
  logic             m_zero_q;
  logic             b_zero_q;
  logic             busy_q;
  logic             done_q;
  logic             m_cap_q;
  logic             b_cap_q;
  logic [COL_W-1:0] cap_idx_q;

  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q   <= IDLE;
      col_q     <= '0;
      m_row_q   <= '0;
      b_row_q   <= '0;
      m_zero_q  <= 1'b0;
      b_zero_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      m_cap_q   <= 1'b0;
      b_cap_q   <= 1'b0;
      cap_idx_q <= '0;
    end else begin
      done_q    <= 1'b0;
      // ROM data lags the address by one cycle, so remember which slot it is for.
      m_cap_q   <= (state_q == FETCH_M);
      b_cap_q   <= (state_q == FETCH_B);
      cap_idx_q <= col_q;
      case (state_q)
        IDLE: begin
          if (start) begin
            m_row_q  <= mario_row;
            b_row_q  <= block_row;
            m_zero_q <= !mario_en || !row_live(mario_row, MARIO_H);
            b_zero_q <= !block_en || !row_live(block_row, BLOCK_H);
            col_q    <= '0;
            busy_q   <= 1'b1;
            state_q  <= FETCH_M;
          end
        end
        FETCH_M: begin
          if (col_q == M_LAST) begin
            col_q   <= '0;
            state_q <= FETCH_B;
          end else begin
            col_q <= col_q + 1'b1;
          end
        end
        FETCH_B: begin
          if (col_q == B_LAST) begin
            col_q   <= '0;
            state_q <= DRAIN;
          end else begin
            col_q <= col_q + 1'b1;
          end
        end
        DRAIN: begin
          state_q <= COMMIT;
        end
        COMMIT: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          col_q   <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    mario_addr = '0;
    block_addr = '0;
    if (state_q == FETCH_M) mario_addr = rom_addr(m_row_q, col_q, MARIO_W, MARIO_H);
    if (state_q == FETCH_B) block_addr = rom_addr(b_row_q, col_q, BLOCK_W, BLOCK_H);
  end

  logic [MARIO_PIX-1:0] m_wr_data;
  logic [BLOCK_PIX-1:0] b_wr_data;
  logic                 commit;

  assign m_wr_data = m_zero_q ? '0 : mario_q;
  assign b_wr_data = b_zero_q ? '0 : block_q;
  assign commit    = (state_q == COMMIT);

  line_dbuf #(.W(MARIO_W), .PIX(MARIO_PIX)) u_mario_buf (
    .clk     (clk),
    .Reset   (Reset),
    .wr_en   (m_cap_q),
    .wr_idx  (cap_idx_q),
    .wr_data (m_wr_data),
    .commit  (commit),
    .line    (mario_line)
  );

  line_dbuf #(.W(BLOCK_W), .PIX(BLOCK_PIX)) u_block_buf (
    .clk     (clk),
    .Reset   (Reset),
    .wr_en   (b_cap_q),
    .wr_idx  (cap_idx_q),
    .wr_data (b_wr_data),
    .commit  (commit),
    .line    (block_line)
  );

  assign busy      = busy_q;
  assign done      = done_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_sprite_row_fetcher.sv
// Self-checking bench for sprite_row_fetcher: behavioural ROMs, a table of fetch
// vectors, per-cycle timing checks and a line scoreboard.
module tb_sprite_row_fetcher;
  import sprite_pkg::*;

  logic                         clk = 1'b0;
  logic                         Reset;
  logic                         start;
  logic [ROW_W-1:0]             mario_row;
  logic [ROW_W-1:0]             block_row;
  logic                         mario_en;
  logic                         block_en;
  logic [ADDR_W-1:0]            mario_addr;
  logic [MARIO_PIX-1:0]         mario_q;
  logic [ADDR_W-1:0]            block_addr;
  logic [BLOCK_PIX-1:0]         block_q;
  logic                         busy;
  logic                         done;
  logic [MARIO_PIX*MARIO_W-1:0] mario_line;
  logic [BLOCK_PIX*BLOCK_W-1:0] block_line;
  fetch_state_t                 state_dbg;

  int checks = 0;
  int errors = 0;

  logic [MARIO_PIX*MARIO_W-1:0] exp_m_q[$];
  logic [BLOCK_PIX*BLOCK_W-1:0] exp_b_q[$];
  logic [MARIO_PIX*MARIO_W-1:0] vis_m;
  logic [BLOCK_PIX*BLOCK_W-1:0] vis_b;

  typedef struct {
    logic [ROW_W-1:0] mrow;
    logic [ROW_W-1:0] brow;
    logic             men;
    logic             ben;
    bit               m_step;
    bit               b_step;
    int               m_base;
    int               b_base;
    bit               m_zero;
    bit               b_zero;
  } vec_t;

  vec_t vecs[6];

  sprite_row_fetcher dut (
    .clk        (clk),
    .Reset      (Reset),
    .start      (start),
    .mario_row  (mario_row),
    .block_row  (block_row),
    .mario_en   (mario_en),
    .block_en   (block_en),
    .mario_addr (mario_addr),
    .mario_q    (mario_q),
    .block_addr (block_addr),
    .block_q    (block_q),
    .busy       (busy),
    .done       (done),
    .mario_line (mario_line),
    .block_line (block_line),
    .state_dbg  (state_dbg)
  );

  // clock / reset block
  always #5 clk = ~clk;

  function automatic logic [MARIO_PIX-1:0] m_word(input int a);
    return 3'((a * 5 + a / 8) % 8);
  endfunction

  function automatic logic [BLOCK_PIX-1:0] b_word(input int a);
    return 2'((a * 3 + a / 16) % 4);
  endfunction

  always @(posedge clk) begin
    mario_q <= m_word(int'(mario_addr));
    block_q <= b_word(int'(block_addr));
  end

  function automatic logic [MARIO_PIX*MARIO_W-1:0] exp_mline(input int base, input bit zero);
    logic [MARIO_PIX*MARIO_W-1:0] l;
    l = '0;
    if (!zero) for (int c = 0; c < MARIO_W; c++) l[c*MARIO_PIX +: MARIO_PIX] = m_word(base + c);
    return l;
  endfunction

  function automatic logic [BLOCK_PIX*BLOCK_W-1:0] exp_bline(input int base, input bit zero);
    logic [BLOCK_PIX*BLOCK_W-1:0] l;
    l = '0;
    if (!zero) for (int c = 0; c < BLOCK_W; c++) l[c*BLOCK_PIX +: BLOCK_PIX] = b_word(base + c);
    return l;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Drives one fetch starting in the current cycle (T) and checks cycles T+1..T+61.
  // junk: extra start pulses at T+10 and T+30; abort_at: assert Reset in that cycle.
  task automatic do_fetch(input vec_t v, input bit junk, input int abort_at);
    logic [ADDR_W-1:0] em_addr;
    logic [ADDR_W-1:0] eb_addr;
    exp_m_q.push_back(exp_mline(v.m_base, v.m_zero));
    exp_b_q.push_back(exp_bline(v.b_base, v.b_zero));
    mario_row = v.mrow;
    block_row = v.brow;
    mario_en  = v.men;
    block_en  = v.ben;
    start     = 1'b1;
    for (int k = 1; k <= 61; k++) begin
      @(posedge clk);
      #1;
      if (abort_at != 0 && k == abort_at + 1) begin
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_done", 128'(done), 128'(0));
        check("rst_mline", 128'(mario_line), 128'(0));
        check("rst_bline", 128'(block_line), 128'(0));
        check("rst_maddr", 128'(mario_addr), 128'(0));
        check("rst_baddr", 128'(block_addr), 128'(0));
        check("rst_state", 128'(state_dbg), 128'(IDLE));
        void'(exp_m_q.pop_back());
        void'(exp_b_q.pop_back());
        vis_m = '0;
        vis_b = '0;
        Reset = 1'b0;
        return;
      end
      em_addr = '0;
      eb_addr = '0;
      if (v.m_step && k <= 26) em_addr = ADDR_W'(v.m_base + k - 1);
      if (v.b_step && k >= 27 && k <= 58) eb_addr = ADDR_W'(v.b_base + k - 27);
      check("mario_addr", 128'(mario_addr), 128'(em_addr));
      check("block_addr", 128'(block_addr), 128'(eb_addr));
      check("busy", 128'(busy), 128'(k <= 60));
      check("done", 128'(done), 128'(k == 61));
      if (k == 1)  check("state_fm", 128'(state_dbg), 128'(FETCH_M));
      if (k == 27) check("state_fb", 128'(state_dbg), 128'(FETCH_B));
      if (k == 59) check("state_drain", 128'(state_dbg), 128'(DRAIN));
      if (k == 60) check("state_commit", 128'(state_dbg), 128'(COMMIT));
      if (done) begin
        if (exp_m_q.size() == 0) begin
          check("unexpected_done", 128'(1), 128'(0));
        end else begin
          vis_m = exp_m_q.pop_front();
          vis_b = exp_b_q.pop_front();
        end
      end
      check("mario_line", 128'(mario_line), 128'(vis_m));
      check("block_line", 128'(block_line), 128'(vis_b));
      // Row/enable inputs after acceptance must not matter.
      mario_row = ROW_W'($urandom_range(0, 63));
      block_row = ROW_W'($urandom_range(0, 63));
      mario_en  = 1'($urandom_range(0, 1));
      block_en  = 1'($urandom_range(0, 1));
      start     = junk && (k == 10 || k == 30);
      if (abort_at != 0 && k == abort_at) Reset = 1'b1;
    end
  endtask

  initial begin
    vecs[0] = '{mrow: 6'd5,  brow: 6'd10, men: 1'b1, ben: 1'b1, m_step: 1, b_step: 1,
                m_base: 130, b_base: 320, m_zero: 0, b_zero: 0};
    vecs[1] = '{mrow: 6'd7,  brow: 6'd0,  men: 1'b0, ben: 1'b1, m_step: 1, b_step: 1,
                m_base: 182, b_base: 0,   m_zero: 1, b_zero: 0};
    vecs[2] = '{mrow: 6'd40, brow: 6'd3,  men: 1'b1, ben: 1'b1, m_step: 0, b_step: 1,
                m_base: 0,   b_base: 96,  m_zero: 1, b_zero: 0};
    vecs[3] = '{mrow: 6'd31, brow: 6'd31, men: 1'b1, ben: 1'b1, m_step: 1, b_step: 1,
                m_base: 806, b_base: 992, m_zero: 0, b_zero: 0};
    vecs[4] = '{mrow: 6'd0,  brow: 6'd32, men: 1'b1, ben: 1'b1, m_step: 1, b_step: 0,
                m_base: 0,   b_base: 0,   m_zero: 0, b_zero: 1};
    vecs[5] = '{mrow: 6'd12, brow: 6'd20, men: 1'b1, ben: 1'b0, m_step: 1, b_step: 1,
                m_base: 312, b_base: 640, m_zero: 0, b_zero: 1};

    Reset = 1'b1;
    start = 1'b0;
    mario_row = '0;
    block_row = '0;
    mario_en = 1'b0;
    block_en = 1'b0;
    vis_m = '0;
    vis_b = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", 128'(busy), 128'(0));
    check("reset_done", 128'(done), 128'(0));
    check("reset_maddr", 128'(mario_addr), 128'(0));
    check("reset_baddr", 128'(block_addr), 128'(0));
    check("reset_mline", 128'(mario_line), 128'(0));
    check("reset_bline", 128'(block_line), 128'(0));
    check("reset_state", 128'(state_dbg), 128'(IDLE));
    Reset = 1'b0;
    @(posedge clk);
    #1;

    // Idle start=0 keeps the block quiet.
    repeat (4) begin
      @(posedge clk);
      #1;
      check("idle_busy", 128'(busy), 128'(0));
    end

    // Table vectors run back to back: each start lands in the previous T+61.
    for (int i = 0; i < 6; i++) do_fetch(vecs[i], 1'b0, 0);

    // Extra starts while busy are ignored; the next start is again back to back.
    do_fetch(vecs[0], 1'b1, 0);
    do_fetch(vecs[3], 1'b0, 0);

    // Reset in the middle of a fetch discards it.
    do_fetch(vecs[5], 1'b0, 40);
    for (int k = 0; k < 80; k++) begin
      @(posedge clk);
      #1;
      check("post_rst_done", 128'(done), 128'(0));
      check("post_rst_mline", 128'(mario_line), 128'(0));
    end

    check("queue_empty", 128'(exp_m_q.size() + exp_b_q.size()), 128'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
